// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, defaults and sizing helper for the fetch queue
package fetch_queue_pkg;

  localparam int INSTR_W     = 32;
  localparam int DEF_BITSIZE = 64;
  localparam int DEF_DEPTH   = 4;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - entry storage: synchronous write, combinational head read, clear
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int WIDTH = DEF_BITSIZE + INSTR_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int OW    = occ_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push && (count != OW'(DEPTH));
    do_pop  = pop && (count != '0);
    head    = mem[rd_ptr];
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + OW'(1);
      else if (!do_push && do_pop) count <= count - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch issue control with an in-order return queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int BITSIZE = DEF_BITSIZE,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int OW      = occ_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] pc,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_req,
  output logic [BITSIZE-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OW-1:0]      occupancy
);

  localparam int EW = BITSIZE + INSTR_W;

  logic               inflight;
  logic [BITSIZE-1:0] pc_q;
  logic [OW:0]        pending;
  logic               issue;
  logic               push;
  logic               pop;
  logic [EW-1:0]      head;

  // Slot accounting counts the outstanding return so a full queue is never overrun.
  always_comb begin
    pending   = {1'b0, occupancy} + (OW+1)'(inflight);
    issue     = rst && pc_valid && !flush && (pending < (OW+1)'(DEPTH));
    pc_ready  = issue;
    imem_req  = issue;
    imem_addr = issue ? pc : '0;
    out_valid = (occupancy != '0);
    push      = inflight && !flush;
    pop       = out_valid && out_ready && !flush;
    out_pc    = out_valid ? head[EW-1:INSTR_W] : '0;
    out_instr = out_valid ? head[INSTR_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      pc_q     <= '0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) pc_q <= pc;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .wdata ({pc_q, imem_rdata}),
    .pop   (pop),
    .head  (head),
    .count (occupancy)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.BITSIZE(64), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .occupancy  (occupancy)
  );

  // One-cycle-latency instruction memory: word = 0xA0000000 + address.
  always @(posedge clk) imem_rdata <= imem_req ? (32'hA000_0000 + imem_addr[31:0]) : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int occ_fill [8] = '{0, 0, 1, 2, 3, 4, 4, 4};
  int pcv;
  int popped;
  int e;
  int expq[$];

  initial begin
    // reset state
    rst = 1'b0; pc = 64'd5; pc_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_rdy", pc_ready, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_occ", occupancy, 0);

    // streaming pc 0..7
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pc_valid = (k < 8);
      pc = (k < 8) ? 64'(k) : 64'd0;
      #1;
      check("s_rdy", pc_ready, (k < 8));
      if (k < 8) check("s_addr", imem_addr, k);
      if (k >= 2 && k < 10) begin
        check("s_valid", out_valid, 1);
        check("s_pc", out_pc, k - 2);
        check("s_instr", out_instr, 32'hA000_0000 + (k - 2));
      end else begin
        check("s_idle", out_valid, 0);
      end
      tick();
    end

    // fill to full, single pop while full, then drain
    do_reset();
    out_ready = 1'b0; pc_valid = 1'b1; pcv = 0;
    for (int k = 0; k < 8; k++) begin
      pc = 64'(pcv);
      #1;
      check("f_rdy", pc_ready, (k < 4));
      check("f_occ", occupancy, occ_fill[k]);
      if (pc_ready) pcv++;
      tick();
    end
    out_ready = 1'b1; pc = 64'(pcv);
    #1;
    check("p_rdy_full", pc_ready, 0);
    check("p_occ4", occupancy, 4);
    check("p_pc0", out_pc, 0);
    tick();
    out_ready = 1'b0;
    #1;
    check("p_occ3", occupancy, 3);
    check("p_rdy", pc_ready, 1);
    check("p_addr4", imem_addr, 4);
    pcv++;
    tick();
    pc = 64'(pcv);
    #1;
    check("p_occ3b", occupancy, 3);
    check("p_rdy_if", pc_ready, 0);
    tick();
    #1;
    check("p_occ4b", occupancy, 4);
    check("p_rdy4", pc_ready, 0);
    tick();
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      pc = 64'(pcv);
      #1;
      check("d_valid", out_valid, 1);
      check("d_pc", out_pc, j);
      if (pc_ready) pcv++;
      tick();
    end

    // flush with 3 stored and 1 in flight
    do_reset();
    out_ready = 1'b0; pc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 64'(k);
      #1;
      check("x_rdy", pc_ready, 1);
      tick();
    end
    pc = 64'd4; flush = 1'b1;
    #1;
    check("x_occ3", occupancy, 3);
    check("x_rdy_flush", pc_ready, 0);
    tick();
    flush = 1'b0; pc = 64'h40;
    #1;
    check("x_occ0", occupancy, 0);
    check("x_valid0", out_valid, 0);
    check("x_rdy40", pc_ready, 1);
    check("x_addr40", imem_addr, 64'h40);
    tick();
    pc_valid = 1'b0;
    #1;
    check("x_valid1", out_valid, 0);
    tick();
    #1;
    check("x_valid2", out_valid, 1);
    check("x_pc40", out_pc, 64'h40);
    check("x_instr40", out_instr, 32'hA000_0040);
    check("x_occ1", occupancy, 1);
    tick();

    // asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b1; pc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 64'(k);
      tick();
    end
    pc = 64'd4;
    #3;
    rst = 1'b0;
    #1;
    check("a_valid", out_valid, 0);
    check("a_pc", out_pc, 0);
    check("a_instr", out_instr, 0);
    check("a_rdy", pc_ready, 0);
    check("a_req", imem_req, 0);
    check("a_addr", imem_addr, 0);
    check("a_occ", occupancy, 0);
    tick();
    rst = 1'b1; pc = 64'h100;
    #1;
    check("a_rdy1", pc_ready, 1);
    check("a_addr1", imem_addr, 64'h100);
    tick();
    pc_valid = 1'b0;
    #1;
    check("a_novalid", out_valid, 0);
    tick();
    #1;
    check("a_valid2", out_valid, 1);
    check("a_pc100", out_pc, 64'h100);
    tick();

    // 10 wraps with random back-pressure
    do_reset();
    pcv = 0; popped = 0;
    for (int cyc = 0; cyc < 2000 && popped < 40; cyc++) begin
      pc_valid = (pcv < 40);
      pc = 64'(pcv);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("w_sbsize", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check("w_pc", out_pc, e);
          check("w_instr", out_instr, 32'hA000_0000 + e);
        end
        popped++;
      end
      if (pc_ready) begin
        expq.push_back(pcv);
        pcv++;
      end
      tick();
    end
    check("w_popped", popped, 40);
    check("w_left", expq.size(), 0);
    check("w_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter BITSIZE, default 64, width of PC and address paths.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 pc  in  BITSIZE  word address from the program counter.
REQ-006 pc_valid  in  1  pc holds a fetchable address.
REQ-007 pc_ready  out  1  fetch issued this cycle; program counter may advance.
REQ-008 imem_req  out  1  instruction-memory read strobe.
REQ-009 imem_addr  out  BITSIZE  instruction-memory word address.
REQ-010 imem_rdata  in  32  instruction word, valid exactly one cycle after imem_req.
REQ-011 flush  in  1  taken branch (Uncondbranch or Branch&Zero); discard all fetched work.
REQ-012 out_valid  out  1  head entry available to decode.
REQ-013 out_ready  in  1  decode accepts head entry.
REQ-014 out_pc  out  BITSIZE  word address of head entry.
REQ-015 out_instr  out  32  instruction word of head entry.
REQ-016 occupancy  out  clog2(DEPTH)+1  stored entries, excluding in-flight.

Function
REQ-017 Issue condition: pc_valid=1, flush=0, rst deasserted, occupancy + inflight < DEPTH.
REQ-018 On issue: pc_ready=1, imem_req=1, imem_addr=pc, all combinational in the same cycle.
REQ-019 When not issuing: pc_ready=0, imem_req=0, imem_addr=0.
REQ-020 One cycle after an issue: push {pc captured at issue, imem_rdata} at the tail; fixed latency 1.
REQ-021 At most one request in flight at a time; inflight is a single flag.
REQ-022 Pop on out_valid=1 and out_ready=1; entries leave in issue order.
REQ-023 out_valid = (occupancy != 0).
REQ-024 out_pc and out_instr show the head entry when out_valid=1, 0 otherwise.
REQ-025 Push and pop in the same cycle: occupancy unchanged, both take effect.
REQ-026 Full (occupancy=DEPTH) or occupancy+inflight=DEPTH: no issue; pc_ready=0.
REQ-027 Pop in a cycle where the queue is full frees a slot, but issue only resumes the following cycle.
REQ-028 Read and write pointers wrap modulo DEPTH with no gap.
REQ-029 flush=1: next posedge clears occupancy, pointers and inflight; the returning imem_rdata is dropped.
REQ-030 flush=1 blocks issue and pc_ready that cycle; flush wins over a simultaneous pop or push.
REQ-031 Issue resumes in the cycle after flush with the redirected pc.
REQ-032 Empty queue with an in-flight return: the entry appears on out_valid in the cycle after the return (no bypass).
REQ-033 Minimum pc-to-out_valid latency is 2 cycles.

Reset
REQ-034 rst=0 asynchronously clears occupancy, pointers, inflight and the captured pc.
REQ-035 During rst=0: out_valid=0, out_pc=0, out_instr=0, pc_ready=0, imem_req=0, imem_addr=0.
REQ-036 Reset asserted with a request in flight: that return is discarded.
REQ-037 First issue can occur in the first cycle with rst=1 and pc_valid=1.

Structure
REQ-038 Shared package holds INSTR_W=32, default BITSIZE, default DEPTH and the occupancy-width function.
REQ-039 Storage is one sub-module, fetch_fifo: synchronous write, combinational head read, clear input.
REQ-040 Issue/inflight control and flush handling reside in fetch_queue.

Verification
REQ-041 Reset; pc=0..7, pc_valid=1, out_ready=1, imem_rdata=0xA0000000+addr -> out_pc 0..7 in order, one per cycle after 2-cycle latency.
REQ-042 out_ready=0, pc_valid=1 -> occupancy reaches 4, pc_ready=0 from then on; out_ready=1 -> entries 0..3 drain in order, then fetch continues at pc=4.
REQ-043 Queue holds 3 entries with 1 in flight, flush=1 -> next cycle occupancy=0, out_valid=0, the return is not pushed; pc=0x40 after flush -> out_pc=0x40 first.
REQ-044 Full queue with a simultaneous pop and pc_valid=1 -> no issue that cycle, issue next cycle, occupancy=3 then 4.
REQ-045 rst driven low mid-stream between clock edges -> outputs are 0 immediately; after release, first out_pc equals the first pc presented.
REQ-046 10 full wrap-arounds of the pointers with random out_ready -> no loss, duplication or reordering against the scoreboard.
